// File: rtl/axi4_lite_slave_regs_if.sv
// rtl/axi4_lite_slave_regs_if.sv - AXI4-Lite bus bundle, 4-bit address and 32-bit data
interface axi4_lite_slave_regs_if;
    logic [3:0]  awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [3:0]  araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    modport master (
        output awaddr, awvalid, wdata, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axi4_lite_slave_regs.sv
// rtl/axi4_lite_slave_regs.sv - AXI4-Lite responder with four 32-bit registers
module axi4_lite_slave_regs #(
    parameter logic [31:0] RESET_VAL = 32'h0000_0000
) (
    input  logic                  i_aclk,
    input  logic                  i_areset,
    axi4_lite_slave_regs_if.slave s_axi,
    output logic [127:0]          o_regs
);
    logic        r_aw_done;
    logic [1:0]  r_aw_addr;
    logic        r_w_done;
    logic [31:0] r_w_data;
    logic        r_bvalid;
    logic        r_rvalid;
    logic [31:0] r_rdata;
    logic [31:0] r_regs [4];

    logic        w_aw_hs;
    logic        w_w_hs;
    logic        w_ar_hs;
    logic        w_commit;
    logic [1:0]  w_addr;
    logic [31:0] w_data;
    logic        w_unused_addr_bits;

    assign s_axi.awready = !r_aw_done && !r_bvalid;
    assign s_axi.wready  = !r_w_done && !r_bvalid;
    assign s_axi.arready = !r_rvalid;
    assign s_axi.bvalid  = r_bvalid;
    assign s_axi.bresp   = 2'b00;
    assign s_axi.rvalid  = r_rvalid;
    assign s_axi.rdata   = r_rdata;
    assign s_axi.rresp   = 2'b00;

    assign w_aw_hs  = s_axi.awvalid && s_axi.awready;
    assign w_w_hs   = s_axi.wvalid && s_axi.wready;
    assign w_ar_hs  = s_axi.arvalid && s_axi.arready;
    assign w_commit = (r_aw_done || w_aw_hs) && (r_w_done || w_w_hs);

    // A half arriving in the commit cycle bypasses its capture register.
    assign w_addr = w_aw_hs ? s_axi.awaddr[3:2] : r_aw_addr;
    assign w_data = w_w_hs  ? s_axi.wdata       : r_w_data;

    assign w_unused_addr_bits = ^{s_axi.awaddr[1:0], s_axi.araddr[1:0]};

    assign o_regs = {r_regs[3], r_regs[2], r_regs[1], r_regs[0]};

    always_ff @(posedge i_aclk or posedge i_areset) begin
        if (i_areset) begin
            r_aw_done <= 1'b0;
            r_aw_addr <= 2'b00;
            r_w_done  <= 1'b0;
            r_w_data  <= 32'h0;
            r_bvalid  <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                r_regs[i] <= RESET_VAL;
            end
        end else begin
            if (w_commit) begin
                r_regs[w_addr] <= w_data;
                r_aw_done      <= 1'b0;
                r_w_done       <= 1'b0;
                r_bvalid       <= 1'b1;
            end else begin
                if (w_aw_hs) begin
                    r_aw_done <= 1'b1;
                    r_aw_addr <= s_axi.awaddr[3:2];
                end
                if (w_w_hs) begin
                    r_w_done <= 1'b1;
                    r_w_data <= s_axi.wdata;
                end
                if (r_bvalid && s_axi.bready) begin
                    r_bvalid <= 1'b0;
                end
            end
        end
    end

    // Non-blocking read of r_regs returns the pre-write value on a same-cycle write.
    always_ff @(posedge i_aclk or posedge i_areset) begin
        if (i_areset) begin
            r_rvalid <= 1'b0;
            r_rdata  <= 32'h0;
        end else begin
            if (w_ar_hs) begin
                r_rvalid <= 1'b1;
                r_rdata  <= r_regs[s_axi.araddr[3:2]];
            end else if (r_rvalid && s_axi.rready) begin
                r_rvalid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_axi4_lite_slave_regs.sv
// tb/tb_axi4_lite_slave_regs.sv - self-checking bench for axi4_lite_slave_regs
module tb_axi4_lite_slave_regs;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [127:0] regs;

    always #5 clk = ~clk;

    axi4_lite_slave_regs_if bus ();

    axi4_lite_slave_regs #(.RESET_VAL(32'h0000_0000)) dut (
        .i_aclk   (clk),
        .i_areset (rst),
        .s_axi    (bus.slave),
        .o_regs   (regs)
    );

    int errors = 0;
    int checks = 0;

    logic [31:0] m_regs [4];
    logic [1:0]  aw_q [$];
    logic [31:0] w_q [$];
    int          b_owed;
    int          r_owed;
    logic [31:0] m_rdata;

    typedef struct {
        logic [3:0]  waddr;
        logic [31:0] wdata;
        logic [3:0]  raddr;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs [6];

    function automatic void chk(string name, logic [127:0] act, logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 4; i++) m_regs[i] = 32'h0;
        aw_q.delete();
        w_q.delete();
        b_owed  = 0;
        r_owed  = 0;
        m_rdata = 32'h0;
    endfunction

    function automatic logic exp_awready();
        return (aw_q.size() == 0) && (b_owed == 0);
    endfunction

    function automatic logic exp_wready();
        return (w_q.size() == 0) && (b_owed == 0);
    endfunction

    function automatic void check_outputs();
        chk("awready", bus.awready, exp_awready());
        chk("wready",  bus.wready,  exp_wready());
        chk("arready", bus.arready, r_owed == 0);
        chk("bvalid",  bus.bvalid,  b_owed != 0);
        chk("bresp",   bus.bresp,   2'b00);
        chk("rvalid",  bus.rvalid,  r_owed != 0);
        chk("rdata",   bus.rdata,   m_rdata);
        chk("rresp",   bus.rresp,   2'b00);
        chk("regs",    regs, {m_regs[3], m_regs[2], m_regs[1], m_regs[0]});
    endfunction

    // One bus cycle: check at the falling edge, advance the model to the rising edge.
    task automatic step();
        logic aw_hs, w_hs, ar_hs;
        @(negedge clk);
        check_outputs();
        aw_hs = bus.awvalid && exp_awready();
        w_hs  = bus.wvalid  && exp_wready();
        ar_hs = bus.arvalid && (r_owed == 0);
        if (b_owed != 0 && bus.bready) b_owed = 0;
        if (r_owed != 0 && bus.rready) r_owed = 0;
        if (ar_hs) begin
            m_rdata = m_regs[bus.araddr[3:2]];
            r_owed  = 1;
        end
        if (aw_hs) aw_q.push_back(bus.awaddr[3:2]);
        if (w_hs)  w_q.push_back(bus.wdata);
        if (aw_q.size() > 0 && w_q.size() > 0) begin
            m_regs[aw_q.pop_front()] = w_q.pop_front();
            b_owed = 1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.awvalid = 1'b0;
        bus.wvalid  = 1'b0;
        bus.arvalid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        bus.awaddr = 4'h0; bus.wdata = 32'h0; bus.araddr = 4'h0;
        bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
        bus.bready = 1'b0; bus.rready = 1'b0;

        vecs[0] = '{4'h0, 32'h0102_0304, 4'h3, 32'h0102_0304};
        vecs[1] = '{4'h5, 32'hFFFF_0000, 4'h4, 32'hFFFF_0000};
        vecs[2] = '{4'hA, 32'h8000_0001, 4'h9, 32'h8000_0001};
        vecs[3] = '{4'hF, 32'h7FFF_FFFF, 4'hC, 32'h7FFF_FFFF};
        vecs[4] = '{4'h4, 32'h0000_0000, 4'h6, 32'h0000_0000};
        vecs[5] = '{4'hC, 32'hFFFF_FFFF, 4'hE, 32'hFFFF_FFFF};

        do_reset();
        step();
        chk("reset_regs", regs, 128'h0);

        // Same-cycle AW and W, BREADY low so BVALID is observed.
        bus.awaddr = 4'h4; bus.wdata = 32'hDEAD_BEEF;
        bus.awvalid = 1'b1; bus.wvalid = 1'b1;
        step();
        idle();
        chk("t1_bvalid", bus.bvalid, 1'b1);
        chk("t1_reg1", regs[63:32], 32'hDEAD_BEEF);
        bus.bready = 1'b1;
        step();
        step();

        // W first, AW three cycles later.
        bus.wdata = 32'h1234_5678; bus.wvalid = 1'b1;
        step();
        bus.wvalid = 1'b0;
        repeat (3) step();
        chk("t2_wready_wait", bus.wready, 1'b0);
        chk("t2_no_commit", regs[127:96], 32'h0);
        bus.awaddr = 4'hC; bus.awvalid = 1'b1;
        step();
        bus.awvalid = 1'b0;
        chk("t2_reg3", regs[127:96], 32'h1234_5678);
        chk("t2_bvalid", bus.bvalid, 1'b1);
        step();

        // BREADY low: new AW/W held off until B completes.
        bus.bready = 1'b0;
        bus.awaddr = 4'h0; bus.wdata = 32'hCAFE_F00D;
        bus.awvalid = 1'b1; bus.wvalid = 1'b1;
        step();
        bus.awaddr = 4'h8; bus.wdata = 32'h1111_1111;
        repeat (5) step();
        chk("t3_awready_blocked", bus.awready, 1'b0);
        chk("t3_reg2_untouched", regs[95:64], 32'h0);
        bus.bready = 1'b1;
        step();
        step();
        idle();
        chk("t3_reg2", regs[95:64], 32'h1111_1111);
        step();

        // Read with RREADY low.
        bus.rready = 1'b0;
        bus.araddr = 4'h4; bus.arvalid = 1'b1;
        step();
        bus.arvalid = 1'b0;
        repeat (3) step();
        chk("t4_rvalid_hold", bus.rvalid, 1'b1);
        chk("t4_rdata", bus.rdata, 32'hDEAD_BEEF);
        chk("t4_arready", bus.arready, 1'b0);
        bus.rready = 1'b1;
        step();
        chk("t4_rvalid_clear", bus.rvalid, 1'b0);

        // Same-cycle write and read of the same register.
        bus.awaddr = 4'h8; bus.wdata = 32'hAAAA_5555; bus.araddr = 4'h8;
        bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.arvalid = 1'b1;
        step();
        idle();
        chk("t5_old_value", bus.rdata, 32'h1111_1111);
        step();
        bus.arvalid = 1'b1;
        step();
        idle();
        chk("t5_new_value", bus.rdata, 32'hAAAA_5555);
        step();

        // Reset with only AW captured and a read pending.
        bus.rready = 1'b0;
        bus.awaddr = 4'h0; bus.awvalid = 1'b1;
        step();
        bus.awvalid = 1'b0;
        bus.araddr = 4'h4; bus.arvalid = 1'b1;
        step();
        idle();
        rst = 1'b1;
        #1;
        chk("t6_rvalid_async", bus.rvalid, 1'b0);
        chk("t6_regs_reset", regs, 128'h0);
        do_reset();
        bus.rready = 1'b1;
        bus.wdata = 32'h0000_0055; bus.wvalid = 1'b1;
        step();
        bus.wvalid = 1'b0;
        repeat (2) step();
        chk("t6_lone_w", regs[31:0], 32'h0);
        bus.awaddr = 4'h0; bus.awvalid = 1'b1;
        step();
        idle();
        chk("t6_commit", regs[31:0], 32'h0000_0055);
        step();

        // Table vectors: write then read back through a different byte offset.
        foreach (vecs[i]) begin
            bus.awaddr = vecs[i].waddr; bus.wdata = vecs[i].wdata;
            bus.awvalid = 1'b1; bus.wvalid = 1'b1;
            step();
            idle();
            step();
            bus.araddr = vecs[i].raddr; bus.arvalid = 1'b1;
            step();
            idle();
            chk($sformatf("vec%0d_rdata", i), bus.rdata, vecs[i].exp_rdata);
            step();
        end

        // Randomized traffic against the reference model.
        for (int n = 0; n < 600; n++) begin
            bus.awaddr  = 4'($urandom_range(0, 15));
            bus.wdata   = $urandom;
            bus.araddr  = 4'($urandom_range(0, 15));
            bus.awvalid = 1'($urandom_range(0, 1));
            bus.wvalid  = 1'($urandom_range(0, 1));
            bus.arvalid = 1'($urandom_range(0, 1));
            bus.bready  = ($urandom_range(0, 3) != 0);
            bus.rready  = ($urandom_range(0, 3) != 0);
            step();
        end
        idle();
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
